// File: rtl/atctlc2axi500_pkg.sv
// Shared types for the stream packer: assembly-buffer FSM states and the packed-word record.
package atctlc2axi500_pkg;

  localparam int PACK_WIDTH = 8;
  localparam int PACK_RATIO = 4;
  localparam int PACK_CW    = $clog2(PACK_RATIO);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  // Layout of one assembled word at the default WIDTH/RATIO.
  typedef struct packed {
    logic [PACK_WIDTH*PACK_RATIO-1:0] data;
    logic [PACK_RATIO-1:0]            mask;
    logic                             last;
    logic [PACK_CW-1:0]               cnt;
  } pack_buf_t;

endpackage

// File: rtl/atctlc2axi500_pack_buf.sv
// One assembly buffer: slot counter, per-slice write enables, mask and last flag.
// Fills slices in order while in FILL, then holds the completed word until read.
module atctlc2axi500_pack_buf
  import atctlc2axi500_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   wr_last,
  input  logic                   rd_en,
  output logic                   full,
  output logic [WIDTH*RATIO-1:0] data,
  output logic [RATIO-1:0]       mask,
  output logic                   last
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

  pack_state_t      state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             last_reg, last_next;
  logic             wr_fire, rd_fire;
  logic [RATIO-1:0] slice_we;
  logic [WIDTH-1:0] slice_reg [RATIO];
  logic [RATIO-1:0] mask_reg;

  assign wr_fire = wr_en && (state_reg == FILL);
  assign rd_fire = rd_en && (state_reg == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    last_next  = last_reg;
    case (state_reg)
      FILL: begin
        if (wr_fire) begin
          // Counter wraps by explicit clear on read-out, never by overflow.
          if ((cnt_reg == CNT_MAX) || wr_last) begin
            state_next = HOLD;
            last_next  = wr_last;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end
      HOLD: begin
        if (rd_fire) begin
          state_next = FILL;
          cnt_next   = '0;
          last_next  = 1'b0;
        end
      end
      default: state_next = FILL;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_slice
      assign slice_we[gi]              = wr_fire && (cnt_reg == CW'(gi));
      assign data[gi*WIDTH +: WIDTH]   = slice_reg[gi];
    end
  endgenerate

  // Read-out clears every slice so unfilled slots of the next word read as zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RATIO; i++) begin
      if (reset || rd_fire) begin
        slice_reg[i] <= '0;
        mask_reg[i]  <= 1'b0;
      end else if (slice_we[i]) begin
        slice_reg[i] <= wr_data;
        mask_reg[i]  <= 1'b1;
      end
    end
  end

  assign full = (state_reg == HOLD);
  assign mask = mask_reg;
  assign last = last_reg;

endmodule

// File: rtl/atctlc2axi500_stream_pack.sv
// Packs RATIO narrow FIFO entries into one wide word with slice mask and packet-end flag.
// Define ATCTLC2AXI500_PACK_SKID_EN for a second ping-pong buffer (one word per RATIO cycles).
module atctlc2axi500_stream_pack
  import atctlc2axi500_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]       out_mask,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready
);

`ifdef ATCTLC2AXI500_PACK_SKID_EN
  logic [1:0]             buf_full, buf_wr, buf_rd, buf_last;
  logic [WIDTH*RATIO-1:0] buf_data [2];
  logic [RATIO-1:0]       buf_mask [2];
  logic                   wsel_reg, wsel_next, rsel_reg, rsel_next;
  logic                   in_fire, out_fire, word_done;

  // The write buffer is only ever full when both buffers are holding.
  assign in_ready  = ~reset & ~buf_full[wsel_reg];
  assign in_fire   = in_valid & in_ready;
  assign out_valid = buf_full[rsel_reg];
  assign out_fire  = out_valid & out_ready;
  // Slots fill in order, so mask bit RATIO-2 set means this entry lands in the top slot.
  assign word_done = in_fire & (in_last | buf_mask[wsel_reg][RATIO-2]);

  always_ff @(posedge clk) begin
    if (reset) begin
      wsel_reg <= 1'b0;
      rsel_reg <= 1'b0;
    end else begin
      wsel_reg <= wsel_next;
      rsel_reg <= rsel_next;
    end
  end

  always_comb begin
    wsel_next = wsel_reg ^ word_done;
    rsel_next = rsel_reg ^ out_fire;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      assign buf_wr[gi] = in_fire  & (wsel_reg == 1'(gi));
      assign buf_rd[gi] = out_fire & (rsel_reg == 1'(gi));

      atctlc2axi500_pack_buf #(
        .WIDTH (WIDTH),
        .RATIO (RATIO)
      ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (buf_wr[gi]),
        .wr_data (in_data),
        .wr_last (in_last),
        .rd_en   (buf_rd[gi]),
        .full    (buf_full[gi]),
        .data    (buf_data[gi]),
        .mask    (buf_mask[gi]),
        .last    (buf_last[gi])
      );
    end
  endgenerate

  assign out_data = buf_data[rsel_reg];
  assign out_mask = buf_mask[rsel_reg];
  assign out_last = buf_last[rsel_reg];
`else
  logic buf_full;

  assign in_ready  = ~reset & ~buf_full;
  assign out_valid = buf_full;

  atctlc2axi500_pack_buf #(
    .WIDTH (WIDTH),
    .RATIO (RATIO)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_valid & in_ready),
    .wr_data (in_data),
    .wr_last (in_last),
    .rd_en   (out_valid & out_ready),
    .full    (buf_full),
    .data    (out_data),
    .mask    (out_mask),
    .last    (out_last)
  );
`endif

endmodule

// File: tb/tb_atctlc2axi500_stream_pack.sv
// Directed bench for the stream packer with a word scoreboard filled from a reference packing model.
module tb_atctlc2axi500_stream_pack;
  import atctlc2axi500_pkg::*;

  localparam int WIDTH = PACK_WIDTH;
  localparam int RATIO = PACK_RATIO;
`ifdef ATCTLC2AXI500_PACK_SKID_EN
  localparam logic HOLD_READY  = 1'b1;
  localparam int   TPUT_CYCLES = 41;
`else
  localparam logic HOLD_READY  = 1'b0;
  localparam int   TPUT_CYCLES = 50;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [WIDTH-1:0]       in_data;
  logic                   in_last;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH*RATIO-1:0] out_data;
  logic [RATIO-1:0]       out_mask;
  logic                   out_last;
  logic                   out_valid;
  logic                   out_ready;

  int        errors = 0;
  int        checks = 0;
  int        cyc = 0;
  int        fires = 0;
  int        last_fire_cyc = 0;
  pack_buf_t sb_q[$];
  pack_buf_t model;
  pack_buf_t exp_w;

  atctlc2axi500_stream_pack #(
    .WIDTH (WIDTH),
    .RATIO (RATIO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: an output fire happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      fires++;
      last_fire_cyc = cyc + 1;
      check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        check("word_data", 64'(out_data), 64'(exp_w.data));
        check("word_mask", 64'(out_mask), 64'(exp_w.mask));
        check("word_last", 64'(out_last), 64'(exp_w.last));
        $display("word data=0x%08h mask=%b last=%0d", out_data, out_mask, out_last);
      end
    end
  end

  // Present one entry, wait (bounded) for acceptance, and update the packing model.
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int waited = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 50) check("in_ready_timeout", 64'(in_ready), 64'd1);
    model.data[model.cnt*WIDTH +: WIDTH] = d;
    model.mask[model.cnt] = 1'b1;
    if ((model.cnt == PACK_CW'(RATIO - 1)) || l) begin
      model.last = l;
      sb_q.push_back(model);
      model = '0;
    end else begin
      model.cnt = model.cnt + 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int f0;
    int c0;
    int waited;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    model     = '0;

    @(posedge clk); #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_mask", 64'(out_mask), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full word, back-to-back
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_data", 64'(out_data), 64'h44332211);
    check("full_mask", 64'(out_mask), 64'hF);
    check("full_last", 64'(out_last), 64'd0);
    @(posedge clk); #1;
    check("full_valid_one_cycle", 64'(out_valid), 64'd0);

    // Early last, then a full word must restart at slot 0
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    check("early_data", 64'(out_data), 64'h0000BBAA);
    check("early_mask", 64'(out_mask), 64'h3);
    check("early_last", 64'(out_last), 64'd1);
    @(posedge clk); #1;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    check("restart_data", 64'(out_data), 64'h04030201);
    @(posedge clk); #1;

    // Backpressure: five stalled cycles, then exactly one fire
    out_ready = 1'b0;
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
    f0 = fires;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'hC4C3C2C1);
      check("bp_mask", 64'(out_mask), 64'hF);
      check("bp_last", 64'(out_last), 64'd0);
      check("bp_in_ready", 64'(in_ready), 64'(HOLD_READY));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp_fire_count", 64'(fires - f0), 64'd1);

    // Reset mid-word discards the partial word
    send(8'h91, 1'b0); send(8'h92, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model = '0;
    f0 = fires;
    send(8'hD1, 1'b0); send(8'hD2, 1'b0); send(8'hD3, 1'b0); send(8'hD4, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_fire_count", 64'(fires - f0), 64'd1);

    // Throughput: 40 random entries, continuous handshake
    repeat (2) @(posedge clk);
    #1;
    c0 = cyc;
    f0 = fires;
    for (int i = 0; i < 40; i++) send(WIDTH'($urandom_range(0, 255)), 1'b0);
    waited = 0;
    while (sb_q.size() != 0 && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    check("tput_words", 64'(fires - f0), 64'd10);
    check("tput_cycles", 64'(last_fire_cyc - c0), 64'(TPUT_CYCLES));
    @(posedge clk); #1;

    // Single-entry packet
    send(8'h5C, 1'b1);
    check("single_data", 64'(out_data), 64'h5C);
    check("single_mask", 64'(out_mask), 64'h1);
    check("single_last", 64'(out_last), 64'd1);
    @(posedge clk); #1;
    check("single_valid_drop", 64'(out_valid), 64'd0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
